traffic_conflict_monitor: RTL and testbench
===========================================

Name: traffic_conflict_monitor

Overview:
- Independent safety checker on the intersection lamp bus. It reads the two 3-bit lamp codes driven by the traffic-light controller: highway and side road, encoded 001 = green, 010 = yellow, 100 = red.
- Detects conflicting greens, illegal codes, illegal colour sequences and short yellows, then latches a fault.
- Sits between the controller and the lamp drivers. Passes lamp codes through when healthy; forces flash mode on fault: highway flashing yellow, side road flashing red.

Parameters:
- MIN_YEL_CYC, 100_000_000: minimum clock cycles a yellow must be held on either head (2 s at 50 MHz).
- FLASH_HALF, 25_000_000: cycles per flash half-period in fault mode.
- MAX_SGRN_CYC, 1_000_000_000: side-road green watchdog limit in cycles. Used only with TLM_WATCHDOG_EN.

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst_n, input, 1: asynchronous active-low reset.
- light_highway, input, 3: highway lamp code from the controller.
- light_SR, input, 3: side-road lamp code from the controller.
- clr_fault, input, 1: single-cycle request to clear a latched fault.
- lamp_hw_out, output, 3: highway lamp drive.
- lamp_sr_out, output, 3: side-road lamp drive.
- fault, output, 1: latched fault flag.
- fault_code, output, 3: latched cause. 0 = none, 1 = conflict, 2 = illegal code, 3 = bad sequence, 4 = short yellow, 5 = watchdog.

Behaviour:
- Clock and reset: all registers use posedge clk with async clear on rst_n low.
- Reset values: state = INIT, lamp_hw_out = 100, lamp_sr_out = 100, fault = 0, fault_code = 0, all counters 0.
- Input classification, combinational on the current inputs:
  - legal: each head is exactly one of 001, 010, 100.
  - conflict: neither head is 100.
- State machine, three states: INIT, RUN, FAULT.
- INIT:
  - Lamp outputs held at 100/100.
  - stable_cnt counts consecutive cycles with inputs legal, non-conflicting and unchanged. Any change or violation resets it to 0.
  - When the second such cycle is sampled: go to RUN; load prev_hw/prev_sr with the inputs; clear the yellow counters.
  - No faults are raised in INIT.
- RUN:
  - lamp_*_out <= inputs each cycle (1-cycle latency).
  - Checks are evaluated on the inputs sampled at the current edge against prev_*:
    - conflict.
    - illegal code.
    - bad sequence: a head changes value, and the change is not green→yellow, yellow→red or red→green.
    - short yellow: a head goes yellow→red with its yellow counter < MIN_YEL_CYC.
  - If any check fires, on that same edge: state = FAULT, fault = 1, fault_code = highest-priority cause. Priority: 1 > 2 > 3 > 4 > 5.
  - The offending code is never passed to the lamp outputs; they switch straight to the flash pattern.
- Yellow counters (one per head):
  - Cleared on the edge where the head enters yellow.
  - Increment each cycle while the sampled input is yellow.
  - Saturate at all-ones; width 32.
  - Counter value at the yellow→red edge equals the number of cycles yellow was held, the entry cycle included.
- FAULT:
  - fault and fault_code hold.
  - Flash: on entry, flash_cnt = 0 and phase = 1. flash_cnt counts 0..FLASH_HALF-1, then wraps and toggles phase.
  - lamp_hw_out = phase ? 010 : 000; lamp_sr_out = phase ? 100 : 000.
  - Inputs are ignored except by the clear qualification below.
- Fault clear:
  - clr_fault in FAULT with inputs currently legal and non-conflicting → INIT. fault and fault_code clear on that edge; lamps go to 100/100.
  - Otherwise clr_fault is ignored, including in INIT and RUN.
- Simultaneous events:
  - Several violations on one edge: the priority above decides fault_code.
  - Both heads changing legally on one edge (e.g., HW yellow→red and SR red→green) is allowed.
- Reset asserted mid-operation (any state, including FAULT): immediate return to reset values.

Optional Feature:
- Macro: TLM_WATCHDOG_EN.
- Defined:
  - A side-road green counter clears on the edge SR enters green and increments while SR is green.
  - In RUN, the edge where the counter reaches MAX_SGRN_CYC raises fault 5.
- Undefined: no counter logic; code 5 is never produced.

Test Plan:
Use MIN_YEL_CYC = 4, FLASH_HALF = 3, MAX_SGRN_CYC = 20.
1. Reset; drive 001/100 for 3 cycles → RUN after 2nd sampled cycle; lamp_hw_out = 001, lamp_sr_out = 100 one cycle later; fault = 0.
2. Full legal cycle: HW 001→010 (held 4 cycles)→100, SR 100→001→010 (held 5)→100, HW →001 → fault stays 0; outputs track inputs with 1-cycle lag.
3. HW yellow held 3 cycles then red → fault = 1, code = 4 on that edge; lamp_hw_out sequence 010,010,010,000,000,000,010…; lamp_sr_out 100/000 in step.
4. Drive 001/001 in RUN → code 1. Then clr_fault while inputs are still 001/001 → no change. Then 001/100 with clr_fault → INIT, fault = 0, lamps 100/100.
5. In RUN: HW 001→100 directly → code 3. Separately, HW = 011 → code 2. Separately, 011/001 on one edge → code 1 (priority).
6. With TLM_WATCHDOG_EN: hold SR green 20 cycles → code 5 on the 20th-count edge. Without the macro: same stimulus → fault stays 0.

Source files
------------

// File: rtl/traffic_conflict_monitor.sv
// rtl/traffic_conflict_monitor.sv - lamp-bus safety checker: latches faults and forces flash mode
// Optional side-road green watchdog (fault code 5) is built when TLM_WATCHDOG_EN is defined.
module traffic_conflict_monitor #(
  parameter int unsigned MIN_YEL_CYC  = 100_000_000,
  parameter int unsigned FLASH_HALF   = 25_000_000,
  parameter int unsigned MAX_SGRN_CYC = 1_000_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] light_highway,
  input  logic [2:0] light_SR,
  input  logic       clr_fault,
  output logic [2:0] lamp_hw_out,
  output logic [2:0] lamp_sr_out,
  output logic       fault,
  output logic [2:0] fault_code
);
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] OFF = 3'b000;

  typedef enum logic [1:0] {INIT, RUN, FAULT} state_t;

  state_t      state;
  logic [1:0]  stable_cnt;
  logic [2:0]  prev_hw, prev_sr;
  logic [31:0] yel_cnt_hw, yel_cnt_sr, flash_cnt;
  logic        phase;

  function automatic logic is_legal(input logic [2:0] c);
    return (c == GRN) || (c == YEL) || (c == RED);
  endfunction

  function automatic logic seq_ok(input logic [2:0] p, input logic [2:0] c);
    return (p == c) || (p == GRN && c == YEL) || (p == YEL && c == RED) || (p == RED && c == GRN);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == '1) ? c : c + 32'd1;
  endfunction

  // Entry cycle loads 1 so the count at the yellow->red edge equals cycles held.
  function automatic logic [31:0] run_next(input logic [2:0] p, input logic [2:0] c,
                                           input logic [2:0] col, input logic [31:0] cnt);
    if (c != col)      return cnt;
    else if (p != col) return 32'd1;
    else               return sat_inc(cnt);
  endfunction

  logic        legal, conflict, same_in, bad_seq, short_yel, wd_hit, flash_wrap, nxt_phase;
  logic [2:0]  cause;
  logic [31:0] yel_nxt_hw, yel_nxt_sr;

  always_comb begin
    legal      = is_legal(light_highway) && is_legal(light_SR);
    conflict   = (light_highway != RED) && (light_SR != RED);
    same_in    = (light_highway == prev_hw) && (light_SR == prev_sr);
    bad_seq    = !seq_ok(prev_hw, light_highway) || !seq_ok(prev_sr, light_SR);
    short_yel  = (prev_hw == YEL && light_highway == RED && yel_cnt_hw < MIN_YEL_CYC) ||
                 (prev_sr == YEL && light_SR == RED && yel_cnt_sr < MIN_YEL_CYC);
    yel_nxt_hw = run_next(prev_hw, light_highway, YEL, yel_cnt_hw);
    yel_nxt_sr = run_next(prev_sr, light_SR, YEL, yel_cnt_sr);
    flash_wrap = (flash_cnt == FLASH_HALF - 1);
    nxt_phase  = phase ^ flash_wrap;
    cause      = 3'd0;
    if (conflict)       cause = 3'd1;
    else if (!legal)    cause = 3'd2;
    else if (bad_seq)   cause = 3'd3;
    else if (short_yel) cause = 3'd4;
    else if (wd_hit)    cause = 3'd5;
  end

`ifdef TLM_WATCHDOG_EN
  logic [31:0] sgrn_cnt, sgrn_nxt;

  assign sgrn_nxt = run_next(prev_sr, light_SR, GRN, sgrn_cnt);
  assign wd_hit   = (light_SR == GRN) && (sgrn_nxt >= MAX_SGRN_CYC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             sgrn_cnt <= '0;
    else if (state == INIT) sgrn_cnt <= '0;
    else if (state == RUN)  sgrn_cnt <= sgrn_nxt;
  end
`else
  logic wd_limit_unused;

  assign wd_limit_unused = ^MAX_SGRN_CYC;
  assign wd_hit          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      lamp_hw_out <= RED;
      lamp_sr_out <= RED;
      fault       <= 1'b0;
      fault_code  <= 3'd0;
      stable_cnt  <= '0;
      prev_hw     <= '0;
      prev_sr     <= '0;
      yel_cnt_hw  <= '0;
      yel_cnt_sr  <= '0;
      flash_cnt   <= '0;
      phase       <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          lamp_hw_out <= RED;
          lamp_sr_out <= RED;
          prev_hw     <= light_highway;
          prev_sr     <= light_SR;
          if (legal && !conflict && stable_cnt != 2'd0 && same_in) begin
            state      <= RUN;
            stable_cnt <= '0;
            yel_cnt_hw <= '0;
            yel_cnt_sr <= '0;
          end else if (legal && !conflict && (stable_cnt == 2'd0 || same_in)) begin
            stable_cnt <= stable_cnt + 2'd1;
          end else begin
            stable_cnt <= '0;
          end
        end
        RUN: begin
          if (cause != 3'd0) begin
            // Offending code never reaches the lamps; flash starts on this edge.
            state       <= FAULT;
            fault       <= 1'b1;
            fault_code  <= cause;
            flash_cnt   <= '0;
            phase       <= 1'b1;
            lamp_hw_out <= YEL;
            lamp_sr_out <= RED;
          end else begin
            lamp_hw_out <= light_highway;
            lamp_sr_out <= light_SR;
            prev_hw     <= light_highway;
            prev_sr     <= light_SR;
            yel_cnt_hw  <= yel_nxt_hw;
            yel_cnt_sr  <= yel_nxt_sr;
          end
        end
        FAULT: begin
          if (clr_fault && legal && !conflict) begin
            state       <= INIT;
            fault       <= 1'b0;
            fault_code  <= 3'd0;
            lamp_hw_out <= RED;
            lamp_sr_out <= RED;
            stable_cnt  <= '0;
            prev_hw     <= light_highway;
            prev_sr     <= light_SR;
          end else begin
            flash_cnt   <= flash_wrap ? 32'd0 : flash_cnt + 32'd1;
            phase       <= nxt_phase;
            lamp_hw_out <= nxt_phase ? YEL : OFF;
            lamp_sr_out <= nxt_phase ? RED : OFF;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb/tb_traffic_conflict_monitor.sv - scoreboard bench: directed plan plus random lamp traffic
// Reference model works in edge timestamps; watchdog expectations follow TLM_WATCHDOG_EN.
module tb_traffic_conflict_monitor;
  localparam int MIN_YEL = 4;
  localparam int FH      = 3;
  localparam int MAXG    = 20;
  localparam logic [2:0] G = 3'b001, Y = 3'b010, R = 3'b100, O = 3'b000;

  logic       clk = 1'b0, rst_n = 1'b0, clr_fault = 1'b0;
  logic [2:0] light_highway = R, light_SR = R;
  logic [2:0] lamp_hw_out, lamp_sr_out, fault_code;
  logic       fault;

  traffic_conflict_monitor #(.MIN_YEL_CYC(MIN_YEL), .FLASH_HALF(FH), .MAX_SGRN_CYC(MAXG)) dut (
    .clk(clk), .rst_n(rst_n), .light_highway(light_highway), .light_SR(light_SR),
    .clr_fault(clr_fault), .lamp_hw_out(lamp_hw_out), .lamp_sr_out(lamp_sr_out),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] hw;
    logic [2:0] sr;
    logic       f;
    logic [2:0] code;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0, miscompares = 0;

  // Model state: mode 0=init 1=run 2=fault, times are edge indices
  int         mode, t, run_len, hw_yel_t, sr_yel_t, sr_grn_t, fault_t;
  logic [2:0] last_hw, last_sr, m_code;

  function automatic bit legal_code(input logic [2:0] c);
    return (c == G) || (c == Y) || (c == R);
  endfunction

  function automatic bit step_ok(input logic [2:0] p, input logic [2:0] c);
    return (p == c) || (p == G && c == Y) || (p == Y && c == R) || (p == R && c == G);
  endfunction

  task automatic model_reset();
    mode = 0; t = 0; run_len = 0; last_hw = 3'b000; last_sr = 3'b000; m_code = 3'd0;
  endtask

  task automatic model_edge(input logic [2:0] hw, input logic [2:0] sr, input logic clr,
                            output exp_t e);
    bit ok;
    int code, m0;
    ok = legal_code(hw) && legal_code(sr) && (hw == R || sr == R);
    t++;
    m0 = mode;
    e.hw = R; e.sr = R; e.f = 1'b0; e.code = 3'd0;
    if (m0 == 0) begin
      if (!ok) run_len = 0;
      else if (run_len > 0 && (hw != last_hw || sr != last_sr)) run_len = 0;
      else run_len++;
      last_hw = hw; last_sr = sr;
      if (run_len == 2) begin
        mode = 1; hw_yel_t = t + 1; sr_yel_t = t + 1; sr_grn_t = t + 1;
      end
    end else if (m0 == 1) begin
      code = 0;
      if (hw != R && sr != R) code = 1;
      else if (!legal_code(hw) || !legal_code(sr)) code = 2;
      else if (!step_ok(last_hw, hw) || !step_ok(last_sr, sr)) code = 3;
      else if ((last_hw == Y && hw == R && t - hw_yel_t < MIN_YEL) ||
               (last_sr == Y && sr == R && t - sr_yel_t < MIN_YEL)) code = 4;
`ifdef TLM_WATCHDOG_EN
      else if (sr == G && ((last_sr != G) ? 1 : t - sr_grn_t + 1) >= MAXG) code = 5;
`endif
      if (code != 0) begin
        mode = 2; fault_t = t; m_code = 3'(code);
      end else begin
        if (hw == Y && last_hw != Y) hw_yel_t = t;
        if (sr == Y && last_sr != Y) sr_yel_t = t;
        if (sr == G && last_sr != G) sr_grn_t = t;
        last_hw = hw; last_sr = sr;
        e.hw = hw; e.sr = sr;
      end
    end else begin
      if (clr && ok) begin
        mode = 0; run_len = 0; last_hw = hw; last_sr = sr; m_code = 3'd0;
      end
    end
    if (mode == 2) begin
      e.f = 1'b1; e.code = m_code;
      if (((t - fault_t) / FH) % 2 == 0) begin e.hw = Y; e.sr = R; end
      else begin e.hw = O; e.sr = O; end
    end
  endtask

  task automatic cycle(input logic [2:0] hw, input logic [2:0] sr, input logic clr);
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1; light_highway = hw; light_SR = sr; clr_fault = clr;
    model_edge(hw, sr, clr, e);
    sb.push_back(e);
  endtask

  task automatic hold(input logic [2:0] hw, input logic [2:0] sr, input int n);
    repeat (n) cycle(hw, sr, 1'b0);
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0; clr_fault = 1'b0;
    model_reset();
    e.hw = R; e.sr = R; e.f = 1'b0; e.code = 3'd0;
    sb.push_back(e);
  endtask

  task automatic random_run(input int ncyc);
    int ph, left;
    ph = 0; left = 5;
    for (int i = 0; i < ncyc; i++) begin
      logic [2:0] hw, sr;
      logic       clr;
      if (mode == 2) begin
        hw = G;
        sr = ($urandom_range(0, 3) == 0) ? G : R;
        clr = ($urandom_range(0, 2) == 0);
        ph = 0; left = 4;
      end else begin
        if (left == 0) begin
          ph = (ph + 1) % 4;
          case (ph)
            0:       left = $urandom_range(1, 5);
            2:       left = $urandom_range(1, 24);
            default: left = $urandom_range(2, 6);
          endcase
        end
        left--;
        case (ph)
          0:       begin hw = G; sr = R; end
          1:       begin hw = Y; sr = R; end
          2:       begin hw = R; sr = G; end
          default: begin hw = R; sr = Y; end
        endcase
        if ($urandom_range(0, 39) == 0) hw = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 39) == 0) sr = 3'($urandom_range(0, 7));
        clr = ($urandom_range(0, 15) == 0);
      end
      cycle(hw, sr, clr);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        vectors++;
        if ({lamp_hw_out, lamp_sr_out, fault, fault_code} !== e) begin
          miscompares++;
          $display("FAIL lamp_state @%0t: got hw=%b sr=%b fault=%b code=%0d, want hw=%b sr=%b fault=%b code=%0d",
                   $time, lamp_hw_out, lamp_sr_out, fault, fault_code, e.hw, e.sr, e.f, e.code);
        end
      end
    end
  end

  initial begin
    model_reset();
    do_reset();
    hold(G, R, 3);
    hold(Y, R, 4); hold(R, G, 3); hold(R, Y, 5); hold(G, R, 3);
    hold(Y, R, 3); hold(R, R, 8);
    cycle(G, R, 1'b1); hold(G, R, 3);
    hold(G, G, 2); cycle(G, G, 1'b1); cycle(G, R, 1'b1); hold(G, R, 3);
    cycle(R, R, 1'b0); cycle(G, R, 1'b1); hold(G, R, 3);
    cycle(3'b011, R, 1'b0); cycle(G, R, 1'b1); hold(G, R, 3);
    cycle(3'b011, G, 1'b0); cycle(G, R, 1'b1); hold(G, R, 3);
    hold(Y, R, 4); hold(R, G, 25); hold(R, Y, 4); hold(G, R, 2);
    cycle(G, R, 1'b1); hold(G, R, 3);
    hold(Y, R, 2); do_reset(); hold(G, R, 3);
    hold(G, G, 1); hold(R, R, 2); do_reset();
    hold(G, G, 3); cycle(G, R, 1'b1); hold(Y, R, 6); hold(R, G, 3);
    do_reset(); hold(G, R, 3);
    random_run(2500);
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
